// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared hawk/hacd types and constants for the AXI read arbiter
package hacd_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_ERROR = 2'd3
    } arb_state_e;

    localparam int RD_REQ_PGRD    = 0;
    localparam int RD_REQ_CMPRESN = 1;
    localparam int RD_REQ_BURST   = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/hawk_rr_picker.sv
// rtl/hawk_rr_picker.sv - combinational round-robin picker searching upward from last+1
module hawk_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    // Walk the request vector starting just after the previous winner; first hit wins
    always_comb begin
        int   k;
        logic found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        k       = 0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(i_last) + off) % N;
            if (!found && i_req[k]) begin
                found      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// rtl/hawk_axi_rd_arb.sv - round-robin arbiter for the single HAWK AXI4 read master port
module hawk_axi_rd_arb
    import hacd_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_arvalid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr_i,
    input  logic [NUM_REQ*8-1:0]      req_arlen_i,
    output logic [NUM_REQ-1:0]        req_arready_o,
    output logic [NUM_REQ-1:0]        req_rvalid_o,
    input  logic [NUM_REQ-1:0]        req_rready_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      m_arvalid_o,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic [7:0]                m_arlen_o,
    input  logic                      m_arready_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    output logic                      m_rready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      timeout_err_o,
    output logic                      proto_err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         r_state;
    arb_state_e         w_next_state;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_grant;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_beat_cnt;
    logic [15:0]        r_idle_cnt;
    logic               r_timeout_err;
    logic               r_proto_err;

    logic               w_req_any;
    logic               w_start;
    logic               w_owner_rready;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_waiting;
    logic               w_timeout;

    hawk_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (req_arvalid_i),
        .i_last  (r_last_grant),
        .o_grant (w_pick_onehot),
        .o_idx   (w_pick_idx)
    );

    assign w_req_any      = |req_arvalid_i;
    assign w_start        = (r_state == ARB_IDLE) && w_req_any;
    assign w_owner_rready = |(req_rready_i & r_grant);
    assign w_ar_hs        = (r_state == ARB_ADDR) && m_arready_i;
    assign w_r_hs         = (r_state == ARB_DATA) && m_rvalid_i && w_owner_rready;
    assign w_waiting      = (r_state == ARB_ADDR) || (r_state == ARB_DATA);
    // A handshake in the final allowed cycle still rescues the burst
    assign w_timeout      = w_waiting && !w_ar_hs && !w_r_hs &&
                            (r_idle_cnt == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ERROR is only left through reset
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_req_any) w_next_state = ARB_ADDR;
            end
            ARB_ADDR: begin
                if (w_timeout)    w_next_state = ARB_ERROR;
                else if (w_ar_hs) w_next_state = ARB_DATA;
            end
            ARB_DATA: begin
                if (w_timeout)                  w_next_state = ARB_ERROR;
                else if (w_r_hs && m_rlast_i)   w_next_state = ARB_IDLE;
            end
            default: w_next_state = ARB_ERROR;
        endcase
    end

    // Output decode; arready is suppressed while reset is held so no request sees a lost accept
    always_comb begin
        req_arready_o = '0;
        req_rvalid_o  = '0;
        m_arvalid_o   = 1'b0;
        m_rready_o    = 1'b0;
        rdata_o       = '0;
        rresp_o       = '0;
        rlast_o       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (!rst_i) req_arready_o = w_pick_onehot;
            end
            ARB_ADDR: begin
                m_arvalid_o = 1'b1;
            end
            ARB_DATA: begin
                m_rready_o   = w_owner_rready;
                req_rvalid_o = r_grant & {NUM_REQ{m_rvalid_i}};
                rdata_o      = m_rdata_i;
                rresp_o      = m_rresp_i;
                rlast_o      = m_rlast_i;
            end
            default: ;
        endcase
    end

    assign m_araddr_o    = r_addr;
    assign m_arlen_o     = r_len;
    assign grant_o       = r_grant;
    assign busy_o        = (r_state != ARB_IDLE);
    assign timeout_err_o = r_timeout_err;
    assign proto_err_o   = r_proto_err;

    // Grant bookkeeping, AR field capture, beat counting, hang watchdog and sticky errors
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant  <= IDX_W'(NUM_REQ - 1);
            r_grant       <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant      <= w_pick_onehot;
                r_last_grant <= w_pick_idx;
                r_addr       <= req_araddr_i[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                r_len        <= req_arlen_i[int'(w_pick_idx)*8 +: 8];
                r_idle_cnt   <= '0;
            end

            if (w_ar_hs) begin
                r_beat_cnt <= '0;
            end

            if (w_ar_hs || w_r_hs) begin
                r_idle_cnt <= '0;
            end else if (w_waiting && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end

            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                // rlast early, late, or missing at the expected beat all count as malformed
                if (m_rlast_i != (r_beat_cnt == r_len)) begin
                    r_proto_err <= 1'b1;
                end
                if (m_rlast_i) begin
                    r_grant <= '0;
                end
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// tb/tb_hawk_axi_rd_arb.sv - directed self-checking bench for hawk_axi_rd_arb
module tb_hawk_axi_rd_arb;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TMO     = 40;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rready;
    logic [DATA_W-1:0]         rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      m_arvalid;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic                      m_arready;
    logic                      m_rvalid;
    logic [DATA_W-1:0]         m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rlast;
    logic                      m_rready;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      timeout_err;
    logic                      proto_err;

    int checks = 0;
    int errors = 0;
    int model_last = NUM_REQ - 1;

    hawk_axi_rd_arb #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_arvalid_i (req_arvalid),
        .req_araddr_i  (req_araddr),
        .req_arlen_i   (req_arlen),
        .req_arready_o (req_arready),
        .req_rvalid_o  (req_rvalid),
        .req_rready_i  (req_rready),
        .rdata_o       (rdata),
        .rresp_o       (rresp),
        .rlast_o       (rlast),
        .m_arvalid_o   (m_arvalid),
        .m_araddr_o    (m_araddr),
        .m_arlen_o     (m_arlen),
        .m_arready_i   (m_arready),
        .m_rvalid_i    (m_rvalid),
        .m_rdata_i     (m_rdata),
        .m_rresp_i     (m_rresp),
        .m_rlast_i     (m_rlast),
        .m_rready_o    (m_rready),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_err_o (timeout_err),
        .proto_err_o   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_arvalid = '0;
        req_rready  = '0;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rresp     = 2'b00;
        m_rlast     = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_araddr = '0;
        req_arlen  = '0;
        clear_inputs();
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({grant, busy, m_arvalid, m_rready, req_arready, req_rvalid, timeout_err, proto_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs grant=%b busy=%b arvalid=%b rready=%b arready=%b rvalid=%b to=%b pe=%b required all 0",
                     grant, busy, m_arvalid, m_rready, req_arready, req_rvalid, timeout_err, proto_err);
        end
        tick();
        rst = 1'b0;
        model_last = NUM_REQ - 1;
    endtask

    task automatic test_single();
        req_arvalid = 3'b001;
        req_araddr[0 +: ADDR_W] = 64'h0000_0000_8000_1000;
        req_arlen[0 +: 8] = 8'd0;
        @(negedge clk);
        checks++;
        if (req_arready !== 3'b001) begin
            errors++; $display("FAIL single_arready got=%b required=001", req_arready);
        end
        tick();
        req_arvalid = '0;
        @(negedge clk);
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000_1000 || grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ar got arvalid=%b addr=%h grant=%b busy=%b required 1/80001000/001/1",
                     m_arvalid, m_araddr, grant, busy);
        end
        m_arready = 1'b1;
        tick();
        m_arready  = 1'b0;
        m_rvalid   = 1'b1;
        m_rlast    = 1'b1;
        m_rdata    = 64'hCAFE_0000_0000_0001;
        req_rready = 3'b001;
        @(negedge clk);
        checks++;
        if (req_rvalid !== 3'b001 || m_rready !== 1'b1 || rdata !== 64'hCAFE_0000_0000_0001 || rlast !== 1'b1) begin
            errors++;
            $display("FAIL single_rbeat got rvalid=%b rready=%b data=%h last=%b required 001/1/cafe000000000001/1",
                     req_rvalid, m_rready, rdata, rlast);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL single_done got grant=%b busy=%b pe=%b required 000/0/0", grant, busy, proto_err);
        end
        model_last = 0;
    endtask

    task automatic test_contention();
        logic [2:0] exp;
        int idx;
        tick();
        req_arvalid = 3'b111;
        req_rready  = 3'b111;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        m_rlast     = 1'b1;
        for (int b = 0; b < 6; b++) begin
            idx = (model_last + 1) % NUM_REQ;
            exp = 3'b001 << idx;
            @(negedge clk);
            checks++;
            if (req_arready !== exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL contend_idle burst=%0d got arready=%b busy=%b required %b/0", b, req_arready, busy, exp);
            end
            @(negedge clk);
            checks++;
            if (grant !== exp || m_arvalid !== 1'b1 || req_arready !== 3'b000) begin
                errors++;
                $display("FAIL contend_addr burst=%0d got grant=%b arvalid=%b arready=%b required %b/1/000",
                         b, grant, m_arvalid, req_arready, exp);
            end
            @(negedge clk);
            checks++;
            if (req_rvalid !== exp || req_arready !== 3'b000) begin
                errors++;
                $display("FAIL contend_data burst=%0d got rvalid=%b arready=%b required %b/000", b, req_rvalid, req_arready, exp);
            end
            model_last = idx;
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 3'b000 || proto_err !== 1'b0) begin
            errors++; $display("FAIL contend_end got busy=%b grant=%b pe=%b required 0/000/0", busy, grant, proto_err);
        end
    endtask

    task automatic test_backpressure();
        int beats;
        logic rr, rv;
        logic [63:0] addr2;
        addr2 = 64'h1234_5678_9ABC_DEF0;
        tick();
        req_arvalid = 3'b100;
        req_araddr[2*ADDR_W +: ADDR_W] = addr2;
        req_arlen[2*8 +: 8] = 8'd3;
        @(negedge clk);
        checks++;
        if (req_arready !== 3'b100) begin
            errors++; $display("FAIL bp_arready got=%b required=100", req_arready);
        end
        tick();
        req_arvalid = '0;
        req_araddr[2*ADDR_W +: ADDR_W] = '0;
        req_arlen[2*8 +: 8] = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (m_arvalid !== 1'b1 || m_araddr !== addr2 || m_arlen !== 8'd3 || grant !== 3'b100) begin
                errors++;
                $display("FAIL bp_ar_hold cyc=%0d got arvalid=%b addr=%h len=%0d grant=%b required 1/%h/3/100",
                         c, m_arvalid, m_araddr, m_arlen, grant, addr2);
            end
            if (c < 4) tick();
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 4; c++) begin
            rr = ((c % 3) != 1);
            rv = ((c % 4) != 2);
            req_rready = {rr, 2'b11};
            m_rvalid   = rv;
            m_rdata    = 64'hD000 + 64'(beats);
            m_rlast    = (beats == 3);
            @(negedge clk);
            checks++;
            if (m_rready !== rr || req_rvalid !== {rv, 2'b00}) begin
                errors++;
                $display("FAIL bp_rready cyc=%0d got rready=%b rvalid=%b required %b/%b00", c, m_rready, req_rvalid, rr, rv);
            end
            if (rr && rv) begin
                checks++;
                if (rdata !== 64'hD000 + 64'(beats)) begin
                    errors++; $display("FAIL bp_rdata beat=%0d got=%h required=%h", beats, rdata, 64'hD000 + 64'(beats));
                end
                beats++;
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (beats !== 4 || busy !== 1'b0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL bp_done got beats=%0d busy=%b pe=%b required 4/0/0", beats, busy, proto_err);
        end
        model_last = 2;
    endtask

    task automatic test_proto_err();
        tick();
        req_arvalid = 3'b010;
        req_araddr[1*ADDR_W +: ADDR_W] = 64'h4000;
        req_arlen[1*8 +: 8] = 8'd1;
        @(negedge clk);
        checks++;
        if (req_arready !== 3'b010) begin
            errors++; $display("FAIL pe_arready got=%b required=010", req_arready);
        end
        tick();
        req_arvalid = '0;
        m_arready   = 1'b1;
        tick();
        m_arready  = 1'b0;
        m_rvalid   = 1'b1;
        m_rlast    = 1'b1;
        req_rready = 3'b010;
        m_rresp    = 2'b10;
        @(negedge clk);
        checks++;
        if (rresp !== 2'b10 || req_rvalid !== 3'b010) begin
            errors++; $display("FAIL pe_rresp got resp=%b rvalid=%b required 10/010", rresp, req_rvalid);
        end
        tick();
        clear_inputs();
        req_arvalid = 3'b001;
        req_araddr[0 +: ADDR_W] = 64'h5000;
        req_arlen[0 +: 8] = 8'd0;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b0 || req_arready !== 3'b001) begin
            errors++; $display("FAIL pe_flag got pe=%b busy=%b arready=%b required 1/0/001", proto_err, busy, req_arready);
        end
        tick();
        req_arvalid = '0;
        m_arready   = 1'b1;
        tick();
        m_arready  = 1'b0;
        m_rvalid   = 1'b1;
        m_rlast    = 1'b1;
        req_rready = 3'b001;
        @(negedge clk);
        checks++;
        if (req_rvalid !== 3'b001 || grant !== 3'b001) begin
            errors++; $display("FAIL pe_next_served got rvalid=%b grant=%b required 001/001", req_rvalid, grant);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b1) begin
            errors++; $display("FAIL pe_sticky got busy=%b pe=%b required 0/1", busy, proto_err);
        end
        model_last = 0;
    endtask

    task automatic test_hang();
        tick();
        req_arvalid = 3'b100;
        req_arlen[2*8 +: 8] = 8'd0;
        @(negedge clk);
        checks++;
        if (req_arready !== 3'b100) begin
            errors++; $display("FAIL hang_arready got=%b required=100", req_arready);
        end
        tick();
        req_arvalid = '0;
        m_arready   = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int j = 0; j <= TMO; j++) begin
            @(negedge clk);
            if (j == TMO - 1) begin
                checks++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL hang_early got to=%b busy=%b required 0/1", timeout_err, busy);
                end
            end
            if (j == TMO) begin
                checks++;
                if (timeout_err !== 1'b1) begin
                    errors++; $display("FAIL hang_flag got to=%b required 1", timeout_err);
                end
            end
        end
        tick();
        req_arvalid = 3'b111;
        req_rready  = 3'b111;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_arready !== 3'b000 || req_rvalid !== 3'b000 || m_arvalid !== 1'b0 ||
                m_rready !== 1'b0 || timeout_err !== 1'b1) begin
                errors++;
                $display("FAIL hang_error_state cyc=%0d got arready=%b rvalid=%b arvalid=%b rready=%b to=%b required 000/000/0/0/1",
                         c, req_arready, req_rvalid, m_arvalid, m_rready, timeout_err);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_arvalid = 3'b001;
        req_arlen[0 +: 8] = 8'd3;
        tick();
        req_arvalid = '0;
        m_arready   = 1'b1;
        tick();
        m_arready  = 1'b0;
        m_rvalid   = 1'b1;
        req_rready = 3'b001;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 3'b001 || proto_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre got busy=%b grant=%b pe=%b required 1/001/0", busy, grant, proto_err);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        req_arvalid = 3'b011;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || m_rready !== 1'b0 || m_arvalid !== 1'b0 ||
            req_rvalid !== 3'b000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got grant=%b busy=%b rready=%b arvalid=%b rvalid=%b to=%b required 000/0/0/0/000/0",
                     grant, busy, m_rready, m_arvalid, req_rvalid, timeout_err);
        end
        checks++;
        if (req_arready !== 3'b001) begin
            errors++; $display("FAIL rst_mid_first_winner got arready=%b required=001", req_arready);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_proto_err();
        test_hang();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
